serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal 2..64.
REQ-002 Parameter DIGIT, default 1, bits added per clock; legal values divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to begin an operation with current a, b, cin, sub.
REQ-006 a  input  WIDTH  operand A, unsigned/two's-complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in, used only when sub=0.
REQ-009 sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1, cin ignored).
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse, result valid.
REQ-012 sum  output  WIDTH  result word.
REQ-013 cout  output  1  carry out of MSB (sub=1: 1 means no borrow).
REQ-014 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 State machine with states IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-016 IDLE: start=1 at an edge captures a, ~b or b, carry-in, sub into internal registers and moves to RUN; start=0 stays IDLE.
REQ-017 RUN: each cycle adds the DIGIT LSBs of both operand shift registers plus carry register, shifts result digit into sum shift register MSB end, updates carry register; digit counter 0..N-1.
REQ-018 RUN exits to DONE on the edge completing digit N-1; sum, cout, ovf output registers load on that same edge.
REQ-019 DONE lasts exactly one cycle; done=1, busy=0 during it; next state RUN if start=1 (back-to-back, operands captured), else IDLE.
REQ-020 Latency: start sampled at edge k gives busy=1 for cycles k+1..k+N and done=1 in cycle k+N+1.
REQ-021 busy=1 exactly when state is RUN.
REQ-022 start while RUN is ignored; no queuing; inputs a, b, cin, sub are don't-care outside the capture edge.
REQ-023 sum, cout, ovf hold their last values until the next DONE entry; they do not change during RUN.
REQ-024 Arithmetic modulo 2^WIDTH; cout is bit WIDTH of the full WIDTH+1-bit result.
REQ-025 ovf derived from carries of the final digit only; for DIGIT>1 the carry into MSB is computed inside the last slice.

Reset
REQ-026 rst=1 forces state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter and carry register 0, immediately and independent of clk.
REQ-027 rst asserted during RUN aborts the operation; no done pulse is produced for it.
REQ-028 First start after rst release is accepted on the first rising edge with rst=0.

Structure
REQ-029 Package serial_adder_pkg holds state encoding enum (IDLE, RUN, DONE) and a function computing counter width from WIDTH/DIGIT.
REQ-030 One sub-module, adder_slice: combinational DIGIT-bit ripple adder with carry-in, carry-out, and carry into its top bit (for ovf).
REQ-031 Parameter legality (DIGIT divides WIDTH) checked by elaboration-time assertion.

Verification
REQ-032 WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0, sub=0 -> sum=8'h00, cout=1, ovf=0, done exactly 9 cycles after start edge.
REQ-033 WIDTH=8, DIGIT=1: a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, cout=0, ovf=1; a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, ovf=0.
REQ-034 WIDTH=8, DIGIT=4: a=8'h3C, b=8'h0A, cin=1 -> sum=8'h47, cout=0; busy 2 cycles, done in cycle 3 after start.
REQ-035 start pulsed again mid-RUN with different operands -> ignored; result matches first operands; start held through DONE -> second operation begins, busy next cycle.
REQ-036 rst asserted mid-RUN between edges -> busy, done, sum, cout, ovf zero immediately; no done pulse; subsequent start completes normally.
REQ-037 Exhaustive WIDTH=4, DIGIT in {1,2,4}: all a, b, cin, sub combinations checked against reference model.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that must reach WIDTH/DIGIT - 1; never narrower than 1 bit.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// DIGIT-bit ripple adder; also exposes the carry into its top bit so the
// caller can form signed overflow from the final slice.
module adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o,
  output logic             c_top_o
);

  always_comb begin
    logic [DIGIT:0] c;
    c    = '0;
    c[0] = c_i;
    s_o  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c_o     = c[DIGIT];
    c_top_o = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT cycles per
// operation, result registered on the edge that completes the last digit.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be 2..64 and DIGIT must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0]       dig_sum;
  logic                   dig_cout;
  logic                   dig_ctop;
  logic [WIDTH+DIGIT-1:0] acc_cat;

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i     (a_q[DIGIT-1:0]),
    .b_i     (b_q[DIGIT-1:0]),
    .c_i     (carry_q),
    .s_o     (dig_sum),
    .c_o     (dig_cout),
    .c_top_o (dig_ctop)
  );

  // New digit enters at the MSB end; works even when DIGIT == WIDTH.
  assign acc_cat = {dig_sum, acc_q};

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = acc_cat[WIDTH+DIGIT-1:DIGIT];
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_ctop;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Capture is legal from IDLE and from DONE (back-to-back operation).
    if (start && state_q != RUN) begin
      state_d = RUN;
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Checks five serial_adder configurations against an integer-arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_g[2];
  logic       cin_g[2];
  logic       sub_g[2];
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;

  logic       busy_w[5], done_w[5], cout_w[5], ovf_w[5];
  logic [7:0] sum8_w[2];
  logic [3:0] sum4_w[3];

  int n_of[5] = '{8, 2, 4, 2, 1};
  int w_of[5] = '{8, 8, 4, 4, 4};

  logic [7:0] exp_sum[5];
  logic       exp_cout[5], exp_ovf[5];

  int vectors     = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .start(start_g[0]), .a(a8), .b(b8), .cin(cin_g[0]), .sub(sub_g[0]),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum8_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .start(start_g[0]), .a(a8), .b(b8), .cin(cin_g[0]), .sub(sub_g[0]),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum8_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));
  serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst(rst), .start(start_g[1]), .a(a4), .b(b4), .cin(cin_g[1]), .sub(sub_g[1]),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum4_w[0]), .cout(cout_w[2]), .ovf(ovf_w[2]));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
    .clk(clk), .rst(rst), .start(start_g[1]), .a(a4), .b(b4), .cin(cin_g[1]), .sub(sub_g[1]),
    .busy(busy_w[3]), .done(done_w[3]), .sum(sum4_w[1]), .cout(cout_w[3]), .ovf(ovf_w[3]));
  serial_adder #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
    .clk(clk), .rst(rst), .start(start_g[1]), .a(a4), .b(b4), .cin(cin_g[1]), .sub(sub_g[1]),
    .busy(busy_w[4]), .done(done_w[4]), .sum(sum4_w[2]), .cout(cout_w[4]), .ovf(ovf_w[4]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned result for sum/cout, signed range test for ovf.
  function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic sub,
                                output logic [7:0] s, output logic co, output logic ov);
    int m, ua, ub, r, sa, sb, sr, ci;
    m  = 1 << w;
    ua = int'(a);
    ub = int'(b);
    ci = cin ? 1 : 0;
    r  = sub ? ua - ub : ua + ub + ci;
    co = sub ? (ua >= ub) : (r >= m);
    s  = 8'(((r % m) + m) % m);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = sub ? sa - sb : sa + sb + ci;
    ov = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  function automatic logic [7:0] dut_sum(input int i);
    if (i < 2) return sum8_w[i];
    return {4'b0, sum4_w[i-2]};
  endfunction

  task automatic drive(input int g, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub);
    if (g == 0) begin
      start_g[0] = st; a8 = a; b8 = b; cin_g[0] = cin; sub_g[0] = sub;
    end else begin
      start_g[1] = st; a4 = a[3:0]; b4 = b[3:0]; cin_g[1] = cin; sub_g[1] = sub;
    end
  endtask

  task automatic check_dut(input int i, input int j, input logic eb, input logic ed);
    string t;
    t = $sformatf("dut%0d cyc%0d", i, j);
    chk({t, " busy"}, 64'(busy_w[i]), 64'(eb));
    chk({t, " done"}, 64'(done_w[i]), 64'(ed));
    chk({t, " sum"},  64'(dut_sum(i)), 64'(exp_sum[i]));
    chk({t, " cout"}, 64'(cout_w[i]), 64'(exp_cout[i]));
    chk({t, " ovf"},  64'(ovf_w[i]),  64'(exp_ovf[i]));
  endtask

  // Caller is positioned just after a falling edge; so is the task on return.
  task automatic run_op(input int g, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
    int lo, hi, maxn;
    logic [7:0] ns[5];
    logic       nc[5], nv[5];
    lo   = (g == 0) ? 0 : 2;
    hi   = (g == 0) ? 1 : 4;
    maxn = (g == 0) ? 8 : 4;
    for (int i = lo; i <= hi; i++) model(w_of[i], a, b, cin, sub, ns[i], nc[i], nv[i]);
    drive(g, 1'b1, a, b, cin, sub);
    for (int j = 1; j <= maxn + 2; j++) begin
      @(negedge clk);
      for (int i = lo; i <= hi; i++) begin
        if (j == n_of[i] + 1) begin
          exp_sum[i] = ns[i]; exp_cout[i] = nc[i]; exp_ovf[i] = nv[i];
        end
        check_dut(i, j, j <= n_of[i], j == n_of[i] + 1);
      end
      if (j == 1) drive(g, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  // start held high throughout: operands change mid-RUN (ignored), then get
  // captured again on each DONE edge.
  task automatic hold_test(input logic [7:0] pa, input logic [7:0] pb,
                           input logic [7:0] qa, input logic [7:0] qb);
    logic [7:0] ps[2], qs[2];
    logic       pc[2], pv[2], qc[2], qv[2];
    int         p;
    logic       ed, eb;
    for (int i = 0; i < 2; i++) begin
      model(w_of[i], pa, pb, 1'b0, 1'b0, ps[i], pc[i], pv[i]);
      model(w_of[i], qa, qb, 1'b0, 1'b1, qs[i], qc[i], qv[i]);
    end
    drive(0, 1'b1, pa, pb, 1'b0, 1'b0);
    for (int j = 1; j <= 19; j++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        p  = n_of[i] + 1;
        ed = (j <= 18) && (j % p == 0);
        eb = (j <= 18) && !ed;
        if (ed) begin
          exp_sum[i]  = (j == p) ? ps[i] : qs[i];
          exp_cout[i] = (j == p) ? pc[i] : qc[i];
          exp_ovf[i]  = (j == p) ? pv[i] : qv[i];
        end
        check_dut(i, j + 100, eb, ed);
      end
      if (j == 1)  drive(0, 1'b1, qa, qb, 1'b1, 1'b1);
      if (j == 18) start_g[0] = 1'b0;
    end
  endtask

  task automatic reset_test();
    drive(0, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0);
    drive(1, 1'b1, 8'h09, 8'h06, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre-rst busy w8d1", 64'(busy_w[0]), 64'(1));
    chk("pre-rst busy w4d1", 64'(busy_w[2]), 64'(1));
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_sum[i] = '0; exp_cout[i] = 1'b0; exp_ovf[i] = 1'b0;
      check_dut(i, 200, 1'b0, 1'b0);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) check_dut(i, 201, 1'b0, 1'b0);
    rst = 1'b0;
    run_op(0, 8'h12, 8'h34, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_sum[i] = '0; exp_cout[i] = 1'b0; exp_ovf[i] = 1'b0;
    end
    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < 5; i++) check_dut(i, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(0, 8'h05, 8'h07, 1'b1, 1'b1);
    run_op(0, 8'h3C, 8'h0A, 1'b1, 1'b0);
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1);

    for (int k = 0; k < 150; k++)
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    hold_test(8'h3C, 8'h0A, 8'h05, 8'h07);
    reset_test();

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++)
            run_op(1, 8'(a), 8'(b), 1'(c), 1'(s));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
